// File: rtl/multi_port_mem_ctrl_pkg.sv
// Shared constants and FSM state type for multi_port_mem_ctrl; stands in for the
// old header.vh (MEM_ADDRESS_LEN, default line width, IDLE/BUSY/RESP encodings).
package multi_port_mem_ctrl_pkg;

  localparam int unsigned MEM_ADDRESS_LEN = 32;
  localparam int unsigned LINE_W_DEFAULT  = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/multi_port_mem_ctrl_mem_line_array.sv
// DEPTH x LINE_W line store: synchronous write, registered read port whose
// output resets to zero (the array itself is never reset).
module mem_line_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LINE_W = 128,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_port_mem_ctrl.sv
// Multi-port line-wide memory controller with fixed programmable latency.
// Define MULTI_PORT_MEM_CTRL_RR_EN for round-robin arbitration (default: fixed priority).
module multi_port_mem_ctrl
  import multi_port_mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = MEM_ADDRESS_LEN,
  parameter int unsigned LINE_W    = LINE_W_DEFAULT,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [LINE_W-1:0]           resp_rdata,
  output logic                        busy
);

  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      gnt_q, gnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;

  logic               req_any;
  logic               grant;
  logic               commit;
  logic [PW-1:0]      arb_idx;
  logic               sel_wr;
  logic [IDX_W-1:0]   sel_idx;
  logic [LINE_W-1:0]  sel_wdata;

  // Offset bits and address bits above the index are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  function automatic logic [PW-1:0] first_set(input logic [NUM_PORTS-1:0] v);
    logic          found;
    logic [PW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!found && v[k]) begin
        found = 1'b1;
        idx   = PW'(k);
      end
    end
    return idx;
  endfunction

  assign req_any = |req_valid;

`ifdef MULTI_PORT_MEM_CTRL_RR_EN
  logic [PW-1:0]        ptr_q;
  logic [NUM_PORTS-1:0] hi_mask;
  logic [NUM_PORTS-1:0] masked_req;

  // Ports at or above the pointer are searched first, then the search wraps.
  always_comb begin
    hi_mask = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      hi_mask[k] = (PW'(k) >= ptr_q);
    end
    masked_req = req_valid & hi_mask;
    arb_idx    = (|masked_req) ? first_set(masked_req) : first_set(req_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (grant) begin
      ptr_q <= (arb_idx == PW'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
    end
  end
`else
  always_comb begin
    arb_idx = first_set(req_valid);
  end
`endif

  always_comb begin
    sel_wr    = 1'b0;
    sel_idx   = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (arb_idx == PW'(k)) begin
        sel_wr    = req_write[k];
        sel_idx   = req_addr[k*ADDR_W + OFF_W +: IDX_W];
        sel_wdata = req_wdata[k*LINE_W +: LINE_W];
      end
    end
  end

  // The edge that ends RESP may already grant the next request, giving one
  // transaction per LATENCY+1 cycles; the served requester has dropped by then.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (req_any) begin
          grant   = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
          gnt_d   = arb_idx;
          wr_d    = sel_wr;
          idx_d   = sel_idx;
          wdata_d = sel_wdata;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  assign commit = (state_q == ST_BUSY) && (cnt_q == '0);

  mem_line_array #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (commit && wr_q),
    .re_i    (commit && !wr_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (resp_rdata)
  );

  always_comb begin
    resp_valid = '0;
    if (state_q == ST_RESP) resp_valid[gnt_q] = 1'b1;
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// Scoreboard bench for multi_port_mem_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares port, data and arrival cycle.
module tb_multi_port_mem_ctrl;

  localparam int NP  = 2;
  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int DEP = 16;
  localparam int LAT = 5;

  localparam logic [LW-1:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [LW-1:0] DAA = {16{8'hAA}};
  localparam logic [LW-1:0] D55 = {16{8'h55}};
  localparam logic [LW-1:0] D11 = {16{8'h11}};

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_valid;
  logic [NP-1:0]     req_write;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*LW-1:0]  req_wdata;
  logic [NP-1:0]     resp_valid;
  logic [LW-1:0]     resp_rdata;
  logic              busy;

  multi_port_mem_ctrl #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .LINE_W    (LW),
    .DEPTH     (DEP),
    .LATENCY   (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   port;
    logic [LW-1:0] data;
    int unsigned   at;
  } exp_t;

  exp_t          sbq[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [LW-1:0] last_rd;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid !== '0) begin
      if (sbq.size() == 0) begin
        check("unexpected_resp", LW'(resp_valid), '0);
      end else begin
        exp_t          e;
        logic [NP-1:0] oh;
        e  = sbq.pop_front();
        oh = '0;
        oh[e.port] = 1'b1;
        check("resp_port", LW'(resp_valid), LW'(oh));
        check("resp_rdata", resp_rdata, e.data);
        check("resp_cycle", LW'(cyc), LW'(e.at));
      end
    end
  end

  task automatic set_port(input int p, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [LW-1:0] d);
    req_valid[p]          = v;
    req_write[p]          = w;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*LW +: LW] = d;
  endtask

  // Write responses leave resp_rdata at the last read value (or zero after reset).
  task automatic expect_resp(input int p, input logic w, input logic [LW-1:0] d, input int unsigned at);
    exp_t e;
    e.port = p;
    e.at   = at;
    if (w) begin
      e.data = last_rd;
    end else begin
      e.data  = d;
      last_rd = d;
    end
    sbq.push_back(e);
  endtask

  task automatic wait_resp(input int p, input string name);
    bit got;
    got = 1'b0;
    for (int unsigned n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (resp_valid[p]) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no response on port %0d within 30 cycles", name, p);
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic txn(input int p, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    @(posedge clk);
    #1;
    set_port(p, 1'b1, w, a, d);
    expect_resp(p, w, d, cyc + LAT + 1);
    wait_resp(p, "txn");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    last_rd   = '0;
    req_valid = NP'($urandom);
    repeat (2) @(negedge clk);
    check("rst_resp_valid", LW'(resp_valid), '0);
    check("rst_busy", LW'(busy), '0);
    check("rst_rdata", resp_rdata, '0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_rst", LW'(busy), '0);
  endtask

  initial begin
    int          pp[4];
    int unsigned c;
    int unsigned seen;
    reset     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    last_rd   = '0;
    do_reset();

    // Write through dcache port, read back through icache port.
    txn(0, 1'b1, 32'h40, D1);
    txn(1, 1'b0, 32'h40, D1);

    // Wrap and offset: 0x100 and 0x00F both map to line 0 with DEPTH=16.
    txn(0, 1'b1, 32'h000, DAA);
    txn(1, 1'b0, 32'h100, DAA);
    txn(0, 1'b0, 32'h00F, DAA);

    // Abort: a write interrupted by reset must not reach the array.
    txn(0, 1'b1, 32'h80, D11);
    @(posedge clk);
    #1;
    set_port(0, 1'b1, 1'b1, 32'h80, D55);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    last_rd = '0;
    @(negedge clk);
    check("abort_busy", LW'(busy), '0);
    check("abort_resp_valid", LW'(resp_valid), '0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    txn(1, 1'b0, 32'h80, D11);

    // Request fields change after grant; the sampled read of 0x40 must stand.
    @(posedge clk);
    #1;
    set_port(1, 1'b1, 1'b0, 32'h40, '0);
    expect_resp(1, 1'b0, D1, cyc + LAT + 1);
    @(posedge clk);
    #1;
    req_addr[AW +: AW]  = 32'h0;
    req_write[1]        = 1'b1;
    req_wdata[LW +: LW] = D55;
    wait_resp(1, "hold");
    txn(0, 1'b0, 32'h000, DAA);

    // Arbitration with both ports requesting continuously from a fresh pointer.
    do_reset();
`ifdef MULTI_PORT_MEM_CTRL_RR_EN
    pp = '{0, 1, 0, 1};
`else
    pp = '{0, 0, 0, 0};
`endif
    @(posedge clk);
    #1;
    set_port(0, 1'b1, 1'b0, 32'h40, '0);
    set_port(1, 1'b1, 1'b0, 32'h000, '0);
    c = cyc;
    for (int unsigned i = 0; i < 4; i++) begin
      expect_resp(pp[i], 1'b0, (pp[i] == 1) ? DAA : D1, c + (LAT + 1) * (i + 1));
    end
    seen = 0;
    for (int unsigned n = 0; n < 60 && seen < 4; n++) begin
      @(negedge clk);
      if (resp_valid !== '0) seen++;
    end
    req_valid = '0;
    if (seen < 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL arb_timeout: saw %0d responses, expected 4", seen);
    end

    repeat (12) @(negedge clk);
    check("sb_drained", LW'(sbq.size()), '0);
    check("final_idle", LW'(busy), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
